knn_result_reader: RTL

// Drain side of the KNN accelerator. After the accelerator signals `done`, this block reads the k

---
 rtl/knn_result_reader_if.sv | 43 ++++
 rtl/knn_result_reader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/knn_result_reader_if.sv
// knn_result_reader_if
// Bundles the sorter read port, the done/k control inputs and the
// valid/ready result stream of the KNN result reader.
//   slave  : reader side (knn_result_reader)
//   master : accelerator / sorter / host side
// Signals:
//   done, k                  accelerator control (k sampled on done)
//   rd_en                    sorter read strobe
//   dataNameIn, dataValueIn  sorter result, valid READ_LATENCY after rd_en
//   m_valid, m_ready         output stream handshake
//   m_name, m_value, m_index, m_last   output beat payload
//   busy, results_done, k_clamped, done_overrun   status
interface knn_result_reader_if #(
    parameter int unsigned dataWidth = 32
);
    logic                 done;
    logic [31:0]          k;
    logic                 rd_en;
    logic [31:0]          dataNameIn;
    logic [dataWidth-1:0] dataValueIn;
    logic                 m_valid;
    logic                 m_ready;
    logic [31:0]          m_name;
    logic [dataWidth-1:0] m_value;
    logic [31:0]          m_index;
    logic                 m_last;
    logic                 busy;
    logic                 results_done;
    logic                 k_clamped;
    logic                 done_overrun;

    modport slave (
        input  done, k, dataNameIn, dataValueIn, m_ready,
        output rd_en, m_valid, m_name, m_value, m_index, m_last,
               busy, results_done, k_clamped, done_overrun
    );

    modport master (
        output done, k, dataNameIn, dataValueIn, m_ready,
        input  rd_en, m_valid, m_name, m_value, m_index, m_last,
               busy, results_done, k_clamped, done_overrun
    );
endinterface

// File: rtl/knn_result_reader.sv
// knn_result_reader
// Drains the k sorted nearest-neighbour results from the sorter after the
// accelerator pulses done. Each result is fetched with a one-cycle rd_en
// strobe, captured READ_LATENCY cycles later, and offered as one beat on a
// valid/ready stream with its rank (m_index) and a last-beat flag.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high; clears all state and outputs
//   bus    knn_result_reader_if.slave (control, sorter read port, stream,
//          status flags)
// Parameters:
//   dataWidth     width of the distance value
//   READ_LATENCY  rd_en to sorter data valid, 1..7 cycles
//   MAX_K         largest k serviced; larger k is clamped
module knn_result_reader #(
    parameter int unsigned dataWidth    = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_K        = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    knn_result_reader_if.slave    bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] EMIT = 2'd3;

    logic [1:0]           r_state;
    logic [31:0]          r_kReg;
    logic [31:0]          r_count;
    logic [2:0]           r_lat;
    logic                 r_rd_en;
    logic                 r_m_valid;
    logic [31:0]          r_m_name;
    logic [dataWidth-1:0] r_m_value;
    logic [31:0]          r_m_index;
    logic                 r_m_last;
    logic                 r_busy;
    logic                 r_results_done;
    logic                 r_k_clamped;
    logic                 r_done_overrun;

    logic                 w_k_over;
    logic [31:0]          w_k_eff;
    logic                 w_handshake;

    assign w_k_over    = bus.k > 32'(MAX_K);
    assign w_k_eff     = w_k_over ? 32'(MAX_K) : bus.k;
    assign w_handshake = r_m_valid && bus.m_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_kReg         <= '0;
            r_count        <= '0;
            r_lat          <= '0;
            r_rd_en        <= 1'b0;
            r_m_valid      <= 1'b0;
            r_m_name       <= '0;
            r_m_value      <= '0;
            r_m_index      <= '0;
            r_m_last       <= 1'b0;
            r_busy         <= 1'b0;
            r_results_done <= 1'b0;
            r_k_clamped    <= 1'b0;
            r_done_overrun <= 1'b0;
        end else begin
            // Strobes default low; set only on the transition that needs them.
            r_rd_en        <= 1'b0;
            r_results_done <= 1'b0;

            if (bus.done && (r_state != IDLE))
                r_done_overrun <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (bus.done) begin
                        r_kReg      <= w_k_eff;
                        r_k_clamped <= w_k_over;
                        r_count     <= '0;
                        if (w_k_eff == 32'd0) begin
                            r_results_done <= 1'b1;
                        end else begin
                            // rd_en is registered, so it is raised here to
                            // be high during the single READ cycle.
                            r_state <= READ;
                            r_rd_en <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    r_lat   <= 3'(READ_LATENCY);
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Counter reaches 1 in the cycle the sorter data is valid.
                    if (r_lat == 3'd1) begin
                        r_m_name  <= bus.dataNameIn;
                        r_m_value <= bus.dataValueIn;
                        r_m_index <= r_count;
                        r_m_last  <= (r_count == (r_kReg - 32'd1));
                        r_m_valid <= 1'b1;
                        r_state   <= EMIT;
                    end else begin
                        r_lat <= r_lat - 3'd1;
                    end
                end
                EMIT: begin
                    if (w_handshake) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        if (r_m_last) begin
                            r_results_done <= 1'b1;
                            r_busy         <= 1'b0;
                            r_state        <= IDLE;
                        end else begin
                            r_count <= r_count + 32'd1;
                            r_rd_en <= 1'b1;
                            r_state <= READ;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_en        = r_rd_en;
    assign bus.m_valid      = r_m_valid;
    assign bus.m_name       = r_m_name;
    assign bus.m_value      = r_m_value;
    assign bus.m_index      = r_m_index;
    assign bus.m_last       = r_m_last;
    assign bus.busy         = r_busy;
    assign bus.results_done = r_results_done;
    assign bus.k_clamped    = r_k_clamped;
    assign bus.done_overrun = r_done_overrun;

endmodule
